// File: rtl/alu_pkg.sv
// Shared definitions for the 4-op ALU and its GCD sequencer.
//   alu_sel_t   : ALU operation select encoding (ADD/SUB/AND/OR)
//   gcd_state_t : sequencer FSM states
//   flags_onehot: true when exactly one of {neg,pos,zero} is set
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_sel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUB_XY = 2'd1,
    SUB_YX = 2'd2,
    DONE   = 2'd3
  } gcd_state_t;

  function automatic logic flags_onehot(input logic neg, input logic pos, input logic zero);
    logic [2:0] f;
    f = {neg, pos, zero};
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
  endfunction

endpackage

// File: rtl/gcd_alu_ctrl.sv
// GCD sequencer driving an external combinational ALU by repeated subtraction.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for go after reset
//   SUB_XY | ALU computes x - y; pos -> x updated, neg -> SUB_YX, zero -> DONE
//   SUB_YX | ALU computes y - x; pos -> y updated, neg -> SUB_XY, zero -> DONE
//   DONE   | result/op_count/err held, go accepted for a new run
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   go, a, b                    start request and operands (sampled in IDLE/DONE)
//   busy, done, err             status; err valid with done
//   result, op_count            GCD and number of ALU ops (saturating)
//   alu_in0, alu_in1, alu_sel   operands/select to the ALU (DATA_WIDTH+1 wide)
//   alu_out, alu_neg/pos/zero   ALU result and flags
module gcd_alu_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] result,
  output logic [CNT_WIDTH-1:0]  op_count,
  output logic [DATA_WIDTH:0]   alu_in0,
  output logic [DATA_WIDTH:0]   alu_in1,
  output logic [1:0]            alu_sel,
  input  logic [DATA_WIDTH:0]   alu_out,
  input  logic                  alu_neg,
  input  logic                  alu_pos,
  input  logic                  alu_zero
);

  gcd_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_x;
  logic [DATA_WIDTH-1:0] r_y;
  logic [DATA_WIDTH-1:0] r_result;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_onehot;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  w_unused_msb;

  // Operands are non-negative and zero-extended, so a difference never
  // needs the extra bit; it only exists to make neg a correct compare.
  assign w_unused_msb = alu_out[DATA_WIDTH];

  assign w_accept  = go && ((r_state == IDLE) || (r_state == DONE));
  assign w_onehot  = flags_onehot(alu_neg, alu_pos, alu_zero);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);

  assign busy     = (r_state == SUB_XY) || (r_state == SUB_YX);
  assign done     = (r_state == DONE);
  assign err      = r_err;
  assign result   = r_result;
  assign op_count = r_cnt;
  assign alu_sel  = SUB;

  always_comb begin
    alu_in0 = '0;
    alu_in1 = '0;
    case (r_state)
      SUB_XY: begin
        alu_in0 = {1'b0, r_x};
        alu_in1 = {1'b0, r_y};
      end
      SUB_YX: begin
        alu_in0 = {1'b0, r_y};
        alu_in1 = {1'b0, r_x};
      end
      default: begin
        alu_in0 = '0;
        alu_in1 = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_x   <= a;
            r_y   <= b;
            r_cnt <= '0;
            r_err <= 1'b0;
            // A zero operand makes the GCD the other operand; skip the ALU.
            if ((a == '0) || (b == '0)) begin
              r_result <= a | b;
              r_state  <= DONE;
            end else begin
              r_state <= SUB_XY;
            end
          end
        end
        SUB_XY: begin
          r_cnt <= w_cnt_inc;
          if (!w_onehot) begin
            r_err    <= 1'b1;
            r_result <= '0;
            r_state  <= DONE;
          end else if (alu_zero) begin
            r_result <= r_x;
            r_state  <= DONE;
          end else if (alu_pos) begin
            r_x <= alu_out[DATA_WIDTH-1:0];
          end else begin
            r_state <= SUB_YX;
          end
        end
        SUB_YX: begin
          r_cnt <= w_cnt_inc;
          if (!w_onehot) begin
            r_err    <= 1'b1;
            r_result <= '0;
            r_state  <= DONE;
          end else if (alu_zero) begin
            r_result <= r_x;
            r_state  <= DONE;
          end else if (alu_pos) begin
            r_y <= alu_out[DATA_WIDTH-1:0];
          end else begin
            r_state <= SUB_XY;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
